// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus bundle: receiver frame inputs, consumer show-ahead read port, status.
// Ports: rx_data/rx_done/parity_odd (receiver), rd_data/rd_perr/rd_valid/rd_ready (consumer),
//        overrun/ovr_clr (sticky drop flag), level (occupancy). slave = FIFO side, master = user side.
interface uart_rx_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_W:0]   rx_data;
    logic              rx_done;
    logic              parity_odd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;
    logic              rd_valid;
    logic              rd_ready;
    logic              overrun;
    logic              ovr_clr;
    logic [LW-1:0]     level;

    modport slave (
        input  rx_data, rx_done, parity_odd, rd_ready, ovr_clr,
        output rd_data, rd_perr, rd_valid, overrun, level
    );

    modport master (
        output rx_data, rx_done, parity_odd, rd_ready, ovr_clr,
        input  rd_data, rd_perr, rd_valid, overrun, level
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: buffers UART receiver frames (data + parity-error flag) in a small show-ahead FIFO.
// Latency: a frame pushed on the rx_done rising edge is visible on rd_* the following cycle.
// Backpressure: rd_valid/rd_ready pop; a push into a full FIFO with no pop drops the frame and sets overrun.
//
// Ports: clk, reset (sync, active-high); bus (uart_rx_fifo_if.slave) carrying
//   rx_data[DATA_W:0] (data + received parity bit), rx_done (frame-complete level), parity_odd,
//   rd_data/rd_perr/rd_valid/rd_ready (head entry), overrun/ovr_clr, level.
// Build option: define UART_RX_PARITY_CHECK_EN to compute the parity-error flag; otherwise it is 0.
module uart_rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_fifo_if.slave        bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    // Storage word: {perr, data}
    logic [DATA_W:0]   mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              overrun_q, overrun_d;
    logic              rx_done_q;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              drop;
    logic              perr;

    // A held-high rx_done yields a single push: only the 0->1 transition counts.
    assign push  = bus.rx_done & ~rx_done_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_L);
    assign pop   = ~empty & bus.rd_ready;

    // When full, a same-edge pop frees the slot the new frame needs.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

`ifdef UART_RX_PARITY_CHECK_EN
    // Total ones across data and parity bit must match the parity sense.
    assign perr = ((^bus.rx_data) != bus.parity_odd);
`else
    logic par_unused;
    assign par_unused = bus.rx_data[DATA_W] ^ bus.parity_odd;
    assign perr = 1'b0;
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Clear first so a coincident drop leaves the flag set.
        if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            rx_done_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            rx_done_q <= bus.rx_done;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= {perr, bus.rx_data[DATA_W-1:0]};
        end
    end

    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = empty ? '0   : mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.rd_perr  = empty ? 1'b0 : mem_q[rd_ptr_q][DATA_W];
    assign bus.overrun  = overrun_q;
    assign bus.level    = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    // ---------------- reference model: a queue of {perr,data} ----------------
    logic [DATA_W:0] mq[$];
    bit              m_ovr;
    bit              m_prev;

    function automatic bit exp_perr(input logic [DATA_W:0] d, input logic po);
`ifdef UART_RX_PARITY_CHECK_EN
        bit odd_ones;
        odd_ones = (($countones(d) % 2) == 1);
        return odd_ones != (po == 1'b1);
`else
        return (d === 'x) && (po === 1'bx);
`endif
    endfunction

    always @(posedge clk) begin
        bit push, pop, full;
        if (reset) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_prev = 1'b0;
        end else begin
            push = bus.rx_done && !m_prev;
            pop  = (mq.size() != 0) && bus.rd_ready;
            full = (mq.size() == DEPTH);
            if (bus.ovr_clr) m_ovr = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (full && !pop) m_ovr = 1'b1;
                else mq.push_back({exp_perr(bus.rx_data, bus.parity_odd), bus.rx_data[DATA_W-1:0]});
            end
            m_prev = bus.rx_done;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model (outputs depend only on state, stable here).
    always @(negedge clk) begin
        if (chk_en) begin
            bit              ev;
            logic [DATA_W:0] head;
            ev   = (mq.size() != 0);
            head = ev ? mq[0] : '0;
            check("m_rd_valid", 32'(bus.rd_valid), 32'(ev));
            check("m_rd_data",  32'(bus.rd_data),  32'(head[DATA_W-1:0]));
            check("m_rd_perr",  32'(bus.rd_perr),  32'(head[DATA_W]));
            check("m_level",    32'(bus.level),    32'(mq.size()));
            check("m_overrun",  32'(bus.overrun),  32'(m_ovr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rx_data = {1'b0, b};
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        tick();
    endtask

    task automatic drain_all();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        bus.rx_data    = '0;
        bus.rx_done    = 1'b0;
        bus.parity_odd = 1'b0;
        bus.rd_ready   = 1'b0;
        bus.ovr_clr    = 1'b0;
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_level",   32'(bus.level),    32'd0);
        check("rst_valid",   32'(bus.rd_valid), 32'd0);
        check("rst_data",    32'(bus.rd_data),  32'd0);
        check("rst_overrun", 32'(bus.overrun),  32'd0);

        // Single frame, even sense
        bus.rx_data = 9'h0A5;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        check("a5_valid", 32'(bus.rd_valid), 32'd1);
        check("a5_data",  32'(bus.rd_data),  32'hA5);
        check("a5_perr",  32'(bus.rd_perr),  32'd0);
        check("a5_level", 32'(bus.level),    32'd1);
        drain_all();
        check("a5_drained", 32'(bus.level), 32'd0);

        // Odd sense on an even-ones frame
        bus.parity_odd = 1'b1;
        push_byte(8'hA5);
`ifdef UART_RX_PARITY_CHECK_EN
        check("odd_perr", 32'(bus.rd_perr), 32'd1);
`else
        check("odd_perr", 32'(bus.rd_perr), 32'd0);
`endif
        check("odd_data", 32'(bus.rd_data), 32'hA5);
        drain_all();
        bus.parity_odd = 1'b0;

        // rx_done held high for 10 cycles -> one entry
        bus.rx_data = 9'h03C;
        bus.rx_done = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.rx_done = 1'b0;
        tick();
        check("hold_level", 32'(bus.level),  32'd1);
        check("hold_model", 32'(mq.size()),  32'd1);
        drain_all();

        // Overrun: five frames into four slots
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        check("ovr_level",   32'(bus.level),   32'd4);
        check("ovr_flag",    32'(bus.overrun), 32'd1);
        check("ovr_model",   32'(mq.size()),   32'd4);
        bus.rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovr_drain", 32'(bus.rd_data), 32'(i));
            tick();
        end
        bus.rd_ready = 1'b0;
        check("ovr_empty", 32'(bus.rd_valid), 32'd0);
        check("ovr_still", 32'(bus.overrun),  32'd1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 32'd0);

        // Full FIFO, push and pop on the same edge
        for (int i = 0; i < 4; i++) push_byte(8'h11 + 8'(i));
        bus.rx_data  = 9'h015;
        bus.rx_done  = 1'b1;
        bus.rd_ready = 1'b1;
        tick();
        bus.rx_done  = 1'b0;
        bus.rd_ready = 1'b0;
        check("pp_level",   32'(bus.level),   32'd4);
        check("pp_overrun", 32'(bus.overrun), 32'd0);
        check("pp_head",    32'(bus.rd_data), 32'h12);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_order", 32'(bus.rd_data), 32'h12 + 32'(i));
            tick();
        end
        bus.rd_ready = 1'b0;

        // Push and pop together while non-full
        push_byte(8'h21);
        bus.rx_data  = 9'h022;
        bus.rx_done  = 1'b1;
        bus.rd_ready = 1'b1;
        tick();
        bus.rx_done  = 1'b0;
        bus.rd_ready = 1'b0;
        check("nf_level", 32'(bus.level),   32'd1);
        check("nf_head",  32'(bus.rd_data), 32'h22);
        drain_all();

        // rd_ready while empty is ignored
        bus.rd_ready = 1'b1;
        tick();
        tick();
        bus.rd_ready = 1'b0;
        check("empty_pop", 32'(bus.level), 32'd0);

        // Overrun coincident with ovr_clr: set wins
        for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
        bus.rx_data = 9'h040;
        bus.rx_done = 1'b1;
        bus.ovr_clr = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.ovr_clr = 1'b0;
        check("setwins", 32'(bus.overrun), 32'd1);
        check("setwins_level", 32'(bus.level), 32'd4);
        drain_all();
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;

        // Reset mid-operation with level 3
        for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i));
        check("mid_level3", 32'(bus.level), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_level", 32'(bus.level),    32'd0);
        check("mid_valid", 32'(bus.rd_valid), 32'd0);
        check("mid_data",  32'(bus.rd_data),  32'd0);

        // rx_done already high when reset releases -> exactly one push
        bus.rx_data = 9'h066;
        bus.rx_done = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_push", 32'(bus.level),   32'd1);
        check("post_rst_data", 32'(bus.rd_data), 32'h66);
        tick();
        tick();
        check("post_rst_once", 32'(bus.level), 32'd1);
        bus.rx_done = 1'b0;
        drain_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
